// File: rtl/mux_rr_param_if.sv
// Handshake bundle between N parallel byte sources and the packing stage.
// The master side drives channel words and downstream ready; the slave is the mux.
interface mux_rr_param_if #(
  parameter int unsigned BW     = 8,
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned CW = $clog2(NUM_CH);

  logic [NUM_CH*BW-1:0] data_in;
  logic [NUM_CH-1:0]    valid_in;
  logic [NUM_CH-1:0]    ready_in;
  logic [BW-1:0]        data_out;
  logic                 valid_out;
  logic [CW-1:0]        ch_out;
  logic                 ready_out;
  logic                 idle;

  modport master (
    output data_in, valid_in, ready_out,
    input  ready_in, data_out, valid_out, ch_out, idle
  );

  modport slave (
    input  data_in, valid_in, ready_out,
    output ready_in, data_out, valid_out, ch_out, idle
  );
endinterface

// File: rtl/mux_rr_param.sv
// N-channel buffered multiplexer: one FIFO per channel feeding a registered
// output slot chosen by fixed TDM order (MODE 0) or work-conserving round-robin (MODE 1).
module mux_rr_param #(
  parameter int unsigned BW     = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned MODE   = 1
) (
  input  logic           clk,
  input  logic           reset,
  mux_rr_param_if.slave  bus
);
  localparam int unsigned CW   = $clog2(NUM_CH);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  if ((NUM_CH < 2) || (NUM_CH > 8)) begin : g_bad_num_ch
    $error("mux_rr_param: NUM_CH must be in 2..8");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("mux_rr_param: DEPTH must be a power of 2, at least 2");
  end

  logic [BW-1:0]   r_mem  [NUM_CH][DEPTH];
  logic [AW-1:0]   r_wptr [NUM_CH];
  logic [AW-1:0]   r_rptr [NUM_CH];
  logic [CNTW-1:0] r_cnt  [NUM_CH];

  logic [CW-1:0]   r_ptr;
  logic            r_valid;
  logic [BW-1:0]   r_data;
  logic [CW-1:0]   r_ch;

  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_ready;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic              w_adv;
  logic              w_gnt;
  logic [CW-1:0]     w_gnt_ch;
  logic [BW-1:0]     w_head;
  logic [CW-1:0]     w_ptr_nxt;
  int unsigned       w_idx;

  // Output slot may be refilled when empty or when its word is being taken.
  assign w_adv = !r_valid || bus.ready_out;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Space is judged from the registered count only, so a full FIFO never bypasses.
    assign w_empty[g] = (r_cnt[g] == '0);
    assign w_full[g]  = (r_cnt[g] == CNTW'(DEPTH));
    assign w_ready[g] = !w_full[g] && !reset;
    assign w_push[g]  = bus.valid_in[g] && w_ready[g];
    assign w_pop[g]   = w_adv && w_gnt && (w_gnt_ch == CW'(g));

    always_ff @(posedge clk) begin
      if (w_push[g]) begin
        r_mem[g][r_wptr[g]] <= bus.data_in[g*BW +: BW];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_wptr[g] <= '0;
        r_rptr[g] <= '0;
        r_cnt[g]  <= '0;
      end else begin
        if (w_push[g]) r_wptr[g] <= r_wptr[g] + AW'(1);
        if (w_pop[g])  r_rptr[g] <= r_rptr[g] + AW'(1);
        r_cnt[g] <= r_cnt[g] + CNTW'(w_push[g]) - CNTW'(w_pop[g]);
      end
    end
  end

  assign bus.ready_in = w_ready;

  // Grant selection: TDM looks at ptr only, round-robin takes the first nonempty from ptr.
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_ch  = '0;
    w_head    = '0;
    w_ptr_nxt = r_ptr;
    w_idx     = 0;
    if (MODE == 0) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if ((CW'(i) == r_ptr) && !w_empty[i]) begin
          w_gnt    = 1'b1;
          w_gnt_ch = CW'(i);
          w_head   = r_mem[i][r_rptr[i]];
        end
      end
      w_ptr_nxt = (r_ptr == CW'(NUM_CH - 1)) ? '0 : r_ptr + CW'(1);
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        w_idx = 32'(r_ptr) + k;
        if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
        if (!w_gnt && !w_empty[w_idx]) begin
          w_gnt     = 1'b1;
          w_gnt_ch  = CW'(w_idx);
          w_head    = r_mem[w_idx][r_rptr[w_idx]];
          w_ptr_nxt = (w_idx == NUM_CH - 1) ? '0 : CW'(w_idx + 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_ptr   <= '0;
    end else if (w_adv) begin
      r_valid <= w_gnt;
      r_ptr   <= w_ptr_nxt;
      if (w_gnt) begin
        r_data <= w_head;
        r_ch   <= w_gnt_ch;
      end
    end
  end

  assign bus.data_out  = r_data;
  assign bus.valid_out = r_valid;
  assign bus.ch_out    = r_ch;
  assign bus.idle      = (&w_empty) && !r_valid;
endmodule
